player_controller: RTL
======================

Name: player_controller

Overview:
- Parametrised per-frame player ship controller for the space-invaders datapath.
- Consumes already-decoded direction and fire key levels plus a collision pulse.
- Produces the ship top-left position, visibility, life count, a fire strobe with shot origin, and game-over status.
- Output feeds the square/bitmap drawing chain and the shot spawner. Adds speed, bounds, lives, respawn, invulnerability blink and fire cooldown.

Parameters:
- OBJECT_WIDTH_X, 32, ship width in pixels
- OBJECT_HEIGHT_Y, 32, ship height in pixels
- START_X, 304, spawn/reset top-left X
- START_Y, 400, spawn/reset top-left Y
- MIN_X, 0, leftmost allowed topLeftX
- MAX_X, 639, rightmost pixel the ship may cover
- MIN_Y, 240, topmost allowed topLeftY
- MAX_Y, 479, bottom pixel the ship may cover
- SPEED, 4, pixels moved per frame per axis (1..31)
- LIVES, 3, initial lives (1..15)
- RESPAWN_FRAMES, 60, frames hidden after a hit
- INVULN_FRAMES, 120, frames of invulnerability after respawn
- BLINK_PERIOD, 8, frames per visible/hidden half-cycle while invulnerable
- FIRE_COOLDOWN, 16, frames between accepted shots

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous active-low reset, sampled on rising clk
- startOfFrame  in  1  one-cycle pulse per video frame
- move_left  in  1  level, key held
- move_right  in  1  level, key held
- move_up  in  1  level, key held
- move_down  in  1  level, key held
- fire_key  in  1  level, fire key held
- hit  in  1  one-cycle collision pulse
- topLeftX  out  11 signed  ship top-left X
- topLeftY  out  11 signed  ship top-left Y
- visible  out  1  drawing enable for the ship
- invulnerable  out  1  high in INVULN
- lives_left  out  4  remaining lives
- fire_pulse  out  1  one-cycle shot strobe
- shotX  out  11 signed  shot origin X, latched with fire_pulse
- shotY  out  11 signed  shot origin Y, latched with fire_pulse
- game_over  out  1  high in GAME_OVER

Behaviour:
- All logic is in the clk domain. resetN is synchronous active-low: when 0 at a rising edge, every register takes its reset value. This applies mid-operation as well.
- Reset values:
  - topLeftX=START_X, topLeftY=START_Y
  - visible=1, invulnerable=0, lives_left=LIVES
  - fire_pulse=0, shotX=0, shotY=0
  - game_over=0, state=ALIVE
  - all counters 0, fire_key history=0
- States:
  - ALIVE: movement on, fire on, hit accepted.
    - On hit: lives_left decrements by 1.
    - If the result is 0, go to GAME_OVER. Otherwise go to DYING, load resp_cnt=RESPAWN_FRAMES, and set visible=0.
  - DYING: no movement, no fire, hit ignored.
    - resp_cnt decrements on each startOfFrame.
    - When a startOfFrame sees resp_cnt==1: topLeftX/Y reset to START_X/START_Y, go to INVULN, load inv_cnt=INVULN_FRAMES, clear blink counter, visible=1, invulnerable=1.
  - INVULN: movement on, fire on, hit ignored.
    - On each startOfFrame, inv_cnt decrements and the blink counter advances. visible toggles every BLINK_PERIOD frames, starting visible.
    - When a startOfFrame sees inv_cnt==1: go to ALIVE, visible=1, invulnerable=0.
  - GAME_OVER: terminal until reset. Position frozen, visible=0, game_over=1, fire disabled, hit ignored.
- Movement is evaluated only in the cycle where startOfFrame=1; registers update on that edge.
  - X axis: left-only gives X-=SPEED. right-only gives X+=SPEED. Both or neither leaves X unchanged.
  - Y axis follows the same rule: up gives -SPEED, down gives +SPEED.
  - Clamping: X to [MIN_X, MAX_X-OBJECT_WIDTH_X+1]; Y to [MIN_Y, MAX_Y-OBJECT_HEIGHT_Y+1]. Compute in 12-bit signed so there is no wrap before the clamp.
- Fire:
  - Rising edge means fire_key=1 with the previous-cycle sample=0.
  - Fire is accepted when there is a rising edge, state is ALIVE or INVULN, and cooldown==0.
  - On acceptance, the next cycle has fire_pulse=1 for exactly one cycle and shotX=topLeftX+OBJECT_WIDTH_X/2, shotY=topLeftY-1, both taken from the current position. cooldown loads FIRE_COOLDOWN.
  - cooldown decrements on startOfFrame while nonzero.
  - A held key does not auto-repeat. A rising edge during cooldown is dropped, not queued.
- Simultaneous events:
  - hit and startOfFrame in the same cycle while ALIVE: hit wins and no movement is applied.
  - hit and fire accept in the same cycle: the hit is processed and the fire is suppressed.
  - A hit on the last life goes directly to GAME_OVER with lives_left=0. lives_left never underflows.

Test Plan:
- Reset, then 10 frames of move_right: topLeftX=304+40=344, topLeftY=400, visible=1.
- Hold move_left from X=304 for 100 frames: X clamps at 0. Hold move_down: Y clamps at 479-32+1=448. Left+right together: X unchanged.
- Press fire at cycle N: fire_pulse=1 at N+1 only, with shotX=topLeftX+16 and shotY=topLeftY-1. Re-press 5 frames later: no pulse. Press at 16 frames: pulse.
- hit while ALIVE: lives 3→2, visible=0 for 60 frames, a second hit is ignored, then respawn at (304,400) with invulnerable=1. visible alternates every 8 frames, and ALIVE resumes after 120 frames.
- Three accepted hits: lives_left=0, game_over=1, visible=0. Movement and fire are ignored. Pulsing resetN low for one cycle restores all reset values.
- Assert resetN=0 mid-DYING and on the same cycle as startOfFrame: the next cycle shows the reset values and no movement is applied.

Source files
------------

// File: rtl/player_controller.sv
// Per-frame player ship controller: movement with clamping, lives/respawn,
// invulnerability blink and rate-limited fire.
module player_controller #(
   parameter int OBJECT_WIDTH_X = 32,
   parameter int OBJECT_HEIGHT_Y = 32,
   parameter int START_X = 304,
   parameter int START_Y = 400,
   parameter int MIN_X = 0,
   parameter int MAX_X = 639,
   parameter int MIN_Y = 240,
   parameter int MAX_Y = 479,
   parameter int SPEED = 4,
   parameter int LIVES = 3,
   parameter int RESPAWN_FRAMES = 60,
   parameter int INVULN_FRAMES = 120,
   parameter int BLINK_PERIOD = 8,
   parameter int FIRE_COOLDOWN = 16
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               move_left,
   input  logic               move_right,
   input  logic               move_up,
   input  logic               move_down,
   input  logic               fire_key,
   input  logic               hit,
   output logic signed [10:0] topLeftX,
   output logic signed [10:0] topLeftY,
   output logic               visible,
   output logic               invulnerable,
   output logic [3:0]         lives_left,
   output logic               fire_pulse,
   output logic signed [10:0] shotX,
   output logic signed [10:0] shotY,
   output logic               game_over
);

   localparam int RESP_W  = $clog2(RESPAWN_FRAMES + 1);
   localparam int INV_W   = $clog2(INVULN_FRAMES + 1);
   localparam int BLINK_W = $clog2(BLINK_PERIOD + 1);
   localparam int COOL_W  = $clog2(FIRE_COOLDOWN + 1);

   // Bounds are kept in 12-bit signed so a step past either edge cannot wrap.
   localparam logic signed [11:0] X_LO = 12'(MIN_X);
   localparam logic signed [11:0] X_HI = 12'(MAX_X - OBJECT_WIDTH_X + 1);
   localparam logic signed [11:0] Y_LO = 12'(MIN_Y);
   localparam logic signed [11:0] Y_HI = 12'(MAX_Y - OBJECT_HEIGHT_Y + 1);
   localparam logic signed [11:0] STEP = 12'(SPEED);

   typedef enum logic [1:0] {ALIVE, DYING, INVULN, GAME_OVER} state_t;

   state_t              state, stateNext;
   logic [RESP_W-1:0]   respCnt, respNext;
   logic [INV_W-1:0]    invCnt, invCntNext;
   logic [BLINK_W-1:0]  blinkCnt, blinkNext;
   logic [COOL_W-1:0]   coolCnt, coolNext;
   logic                fireKeyD;
   logic signed [10:0]  xNext, yNext, shotXNext, shotYNext;
   logic                visNext, invulNext, overNext, pulseNext;
   logic [3:0]          livesNext;
   logic                fireRise, canAct, hitTaken, fireAccept;

   function automatic logic signed [10:0] stepAxis(
      input logic signed [10:0] pos,
      input logic               dec,
      input logic               inc,
      input logic signed [11:0] lo,
      input logic signed [11:0] hi
   );
      logic signed [11:0] s;
      s = {pos[10], pos};
      if (dec && !inc)
         s = s - STEP;
      else if (inc && !dec)
         s = s + STEP;
      if (s < lo)
         s = lo;
      else if (s > hi)
         s = hi;
      return s[10:0];
   endfunction

   assign fireRise   = fire_key & ~fireKeyD;
   assign canAct     = (state == ALIVE) || (state == INVULN);
   assign hitTaken   = (state == ALIVE) && hit;
   // A hit in the same cycle as a press wins; the shot is lost.
   assign fireAccept = fireRise && canAct && (coolCnt == '0) && !hitTaken;

   always_comb begin
      stateNext  = state;
      xNext      = topLeftX;
      yNext      = topLeftY;
      visNext    = visible;
      invulNext  = invulnerable;
      livesNext  = lives_left;
      overNext   = game_over;
      respNext   = respCnt;
      invCntNext = invCnt;
      blinkNext  = blinkCnt;
      coolNext   = coolCnt;
      pulseNext  = 1'b0;
      shotXNext  = shotX;
      shotYNext  = shotY;

      if (startOfFrame && (coolCnt != '0))
         coolNext = coolCnt - 1'b1;
      if (fireAccept) begin
         pulseNext = 1'b1;
         shotXNext = topLeftX + 11'(OBJECT_WIDTH_X / 2);
         shotYNext = topLeftY - 11'sd1;
         coolNext  = COOL_W'(FIRE_COOLDOWN);
      end

      if (canAct && startOfFrame && !hitTaken) begin
         xNext = stepAxis(topLeftX, move_left, move_right, X_LO, X_HI);
         yNext = stepAxis(topLeftY, move_up, move_down, Y_LO, Y_HI);
      end

      case (state)
         ALIVE: begin
            if (hit) begin
               visNext = 1'b0;
               if (lives_left <= 4'd1) begin
                  livesNext = '0;
                  overNext  = 1'b1;
                  stateNext = GAME_OVER;
               end else begin
                  livesNext = lives_left - 4'd1;
                  respNext  = RESP_W'(RESPAWN_FRAMES);
                  stateNext = DYING;
               end
            end
         end
         DYING: begin
            if (startOfFrame) begin
               respNext = respCnt - 1'b1;
               if (respCnt == RESP_W'(1)) begin
                  xNext      = 11'(START_X);
                  yNext      = 11'(START_Y);
                  invCntNext = INV_W'(INVULN_FRAMES);
                  blinkNext  = '0;
                  visNext    = 1'b1;
                  invulNext  = 1'b1;
                  stateNext  = INVULN;
               end
            end
         end
         INVULN: begin
            if (startOfFrame) begin
               invCntNext = invCnt - 1'b1;
               if (invCnt == INV_W'(1)) begin
                  visNext   = 1'b1;
                  invulNext = 1'b0;
                  stateNext = ALIVE;
               end else if (blinkCnt == BLINK_W'(BLINK_PERIOD - 1)) begin
                  blinkNext = '0;
                  visNext   = ~visible;
               end else begin
                  blinkNext = blinkCnt + 1'b1;
               end
            end
         end
         GAME_OVER: begin
            visNext  = 1'b0;
            overNext = 1'b1;
         end
         default: stateNext = ALIVE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state        <= ALIVE;
         topLeftX     <= 11'(START_X);
         topLeftY     <= 11'(START_Y);
         visible      <= 1'b1;
         invulnerable <= 1'b0;
         lives_left   <= 4'(LIVES);
         game_over    <= 1'b0;
         fire_pulse   <= 1'b0;
         shotX        <= '0;
         shotY        <= '0;
         respCnt      <= '0;
         invCnt       <= '0;
         blinkCnt     <= '0;
         coolCnt      <= '0;
         fireKeyD     <= 1'b0;
      end else begin
         state        <= stateNext;
         topLeftX     <= xNext;
         topLeftY     <= yNext;
         visible      <= visNext;
         invulnerable <= invulNext;
         lives_left   <= livesNext;
         game_over    <= overNext;
         fire_pulse   <= pulseNext;
         shotX        <= shotXNext;
         shotY        <= shotYNext;
         respCnt      <= respNext;
         invCnt       <= invCntNext;
         blinkCnt     <= blinkNext;
         coolCnt      <= coolNext;
         fireKeyD     <= fire_key;
      end
   end

endmodule
